instruction_fetch_unit: RTL and testbench

//  Producer side of the instruction register: owns the fetch PC, reads 16-bit instruction words from

---
 rtl/instruction_fetch_unit_pkg.sv | 25 ++
 rtl/instruction_fetch_unit_if.sv | 32 +++
 rtl/instruction_fetch_unit_fifo.sv | 86 ++++++++
 rtl/instruction_fetch_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
// Shared definitions for the instruction fetch unit: the fetch FSM state
// encodings, the default reset PC / PC increment and a width helper for the
// prefetch FIFO occupancy counter.
// -----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

    // Fetch FSM: IDLE (no request), REQ (request out), FLUSH (request out,
    // its response belongs to a stale stream and is dropped).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_FLUSH = 2'b10
    } ifu_state_e;

    localparam logic [15:0] IFU_RESET_PC_DEFAULT = 16'h0000;
    localparam int          IFU_PC_STEP_DEFAULT  = 2;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int ifu_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
// Instruction-memory read bus between the fetch unit (master) and the
// instruction memory (slave).
//   Output_IF_MemReq   master->slave  read request
//   Output_IF_MemAddr  master->slave  read address, held while request is open
//   input_IF_MemAck    slave->master  read complete, data valid this cycle
//   input_IF_MemData   slave->master  instruction word
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              Output_IF_MemReq;
    logic [ADDR_W-1:0] Output_IF_MemAddr;
    logic              input_IF_MemAck;
    logic [DATA_W-1:0] input_IF_MemData;

    modport master (
        output Output_IF_MemReq,
        output Output_IF_MemAddr,
        input  input_IF_MemAck,
        input  input_IF_MemData
    );

    modport slave (
        input  Output_IF_MemReq,
        input  Output_IF_MemAddr,
        output input_IF_MemAck,
        output input_IF_MemData
    );
endinterface

// File: rtl/instruction_fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_fifo
// Synchronous prefetch FIFO holding {instruction, address} entries.
//   clk, rst_n     clock / asynchronous active-low reset
//   push_i         write wdata_i at the tail
//   pop_i          advance the head (caller guarantees non-empty)
//   clear_i        empty the FIFO (overrides push/pop)
//   wdata_i        entry to write
//   rdata_o        head entry
//   count_o        occupancy 0..DEPTH
// Same-cycle push and pop are allowed. DEPTH must be a power of two >= 2 so
// the pointers wrap naturally.
// -----------------------------------------------------------------------------
module instruction_fetch_unit_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy next-state; clear wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; a push in the same cycle as clear is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Producer side of the instruction register. Owns the fetch PC, reads
// instruction words from memory over a req/ack handshake, buffers them in a
// prefetch FIFO and, on request from the control unit, delivers one word with
// a one-cycle IR write strobe.
//   CLK                 clock, rising edge
//   input_IF_Reset_n    asynchronous active-low reset
//   mem_if              instruction memory bus (master modport)
//   input_IF_Fetch      control unit requests the next instruction
//   input_IF_Redirect   branch/jump taken: restart fetch at input_IF_Target
//   input_IF_Target     redirect address
//   Output_IF_Instru    delivered instruction
//   Output_IF_IRWrite   one-cycle strobe, IR must load Output_IF_Instru
//   Output_IF_PC        address of the delivered instruction
//   Output_IF_Valid     prefetch FIFO non-empty
//   Output_IF_StallCnt  cycles spent waiting on a fetch (IFU_PERF_EN only)
// Build option: define IFU_PERF_EN to add the saturating stall counter and
// its output port.
// -----------------------------------------------------------------------------
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(IFU_RESET_PC_DEFAULT),
    parameter int                PC_STEP    = IFU_PC_STEP_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     input_IF_Reset_n,
    instruction_fetch_unit_if.master mem_if,
    input  logic                     input_IF_Fetch,
    input  logic                     input_IF_Redirect,
    input  logic [ADDR_W-1:0]        input_IF_Target,
    output logic [DATA_W-1:0]        Output_IF_Instru,
    output logic                     Output_IF_IRWrite,
    output logic [ADDR_W-1:0]        Output_IF_PC,
    output logic                     Output_IF_Valid
`ifdef IFU_PERF_EN
    ,
    output logic [15:0]              Output_IF_StallCnt
`endif
);

    localparam int                CNT_W   = ifu_cnt_w(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

    ifu_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              pending_q, pending_d;
    logic              irwrite_q, irwrite_d;
    logic [DATA_W-1:0] instru_q, instru_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic                     fifo_push_s, fifo_pop_s, fifo_clear_s;
    logic [DATA_W+ADDR_W-1:0] fifo_wdata_s, fifo_rdata_s;
    logic [CNT_W-1:0]         fifo_count_s, cnt_after_s;
    logic                     fifo_empty_s;
    logic                     mem_ack_s, ack_req_s, fetch_acc_s, bypass_s;

    instruction_fetch_unit_fifo #(
        .WIDTH (DATA_W + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (input_IF_Reset_n),
        .push_i  (fifo_push_s),
        .pop_i   (fifo_pop_s),
        .clear_i (fifo_clear_s),
        .wdata_i (fifo_wdata_s),
        .rdata_o (fifo_rdata_s),
        .count_o (fifo_count_s)
    );

    assign mem_ack_s    = mem_if.input_IF_MemAck;
    assign fifo_wdata_s = {mem_if.input_IF_MemData, mem_addr_q};
    assign fifo_empty_s = (fifo_count_s == {CNT_W{1'b0}});
    assign ack_req_s    = (state_q == ST_REQ) && mem_ack_s;
    // A new fetch is taken only when no request is already waiting and the
    // previous delivery strobe has completed.
    assign fetch_acc_s  = input_IF_Fetch && !pending_q && !irwrite_q;
    // The returning word goes straight to the IR when a fetch is waiting for
    // it, including a fetch that hits an empty FIFO in the ack cycle itself;
    // pushing it instead would leave the waiting fetch unserved.
    assign bypass_s     = ack_req_s && (pending_q || (fetch_acc_s && fifo_empty_s));

    // Fetch FSM, FIFO control and delivery next-state.
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        fetch_pc_d   = fetch_pc_q;
        pending_d    = pending_q;
        irwrite_d    = 1'b0;
        instru_d     = instru_q;
        pc_d         = pc_q;
        fifo_push_s  = 1'b0;
        fifo_pop_s   = 1'b0;
        fifo_clear_s = 1'b0;
        cnt_after_s  = fifo_count_s;

        if (input_IF_Redirect) begin
            // Old stream is dead: nothing from it may reach the IR.
            fifo_clear_s = 1'b1;
            fetch_pc_d   = input_IF_Target;
            pending_d    = pending_q | fetch_acc_s;
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_REQ;
                    mem_addr_d = input_IF_Target;
                end
                ST_REQ, ST_FLUSH: begin
                    if (mem_ack_s) begin
                        state_d    = ST_REQ;
                        mem_addr_d = input_IF_Target;
                    end else begin
                        // Open request must keep its address until acked.
                        state_d    = ST_FLUSH;
                        mem_addr_d = mem_addr_q;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    mem_addr_d = fetch_pc_q;
                end
            endcase
        end else begin
            if (fetch_acc_s && !fifo_empty_s) begin
                fifo_pop_s = 1'b1;
                irwrite_d  = 1'b1;
                instru_d   = fifo_rdata_s[DATA_W+ADDR_W-1:ADDR_W];
                pc_d       = fifo_rdata_s[ADDR_W-1:0];
            end else if (bypass_s) begin
                irwrite_d  = 1'b1;
                instru_d   = mem_if.input_IF_MemData;
                pc_d       = mem_addr_q;
                pending_d  = 1'b0;
            end else if (fetch_acc_s) begin
                pending_d  = 1'b1;
            end else begin
                pending_d  = pending_q;
            end

            fifo_push_s = ack_req_s && !bypass_s;
            cnt_after_s = fifo_count_s - CNT_W'(fifo_pop_s) + CNT_W'(fifo_push_s);

            case (state_q)
                ST_IDLE: begin
                    if (cnt_after_s < DEPTH_C) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_ack_s) begin
                        fetch_pc_d = fetch_pc_q + STEP_C;
                        mem_addr_d = fetch_pc_q + STEP_C;
                        state_d    = (cnt_after_s < DEPTH_C) ? ST_REQ : ST_IDLE;
                    end else begin
                        state_d    = ST_REQ;
                    end
                end
                ST_FLUSH: begin
                    if (mem_ack_s) begin
                        // Stale word dropped; fetch_pc already holds the target.
                        mem_addr_d = fetch_pc_q;
                        state_d    = ST_REQ;
                    end else begin
                        state_d    = ST_FLUSH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        mem_req_d = (state_d != ST_IDLE);
    end

    // State, bus and delivery registers.
    always_ff @(posedge CLK or negedge input_IF_Reset_n) begin
        if (!input_IF_Reset_n) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            pending_q  <= 1'b0;
            irwrite_q  <= 1'b0;
            instru_q   <= {DATA_W{1'b0}};
            pc_q       <= {ADDR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
            pending_q  <= pending_d;
            irwrite_q  <= irwrite_d;
            instru_q   <= instru_d;
            pc_q       <= pc_d;
        end
    end

    assign mem_if.Output_IF_MemReq  = mem_req_q;
    assign mem_if.Output_IF_MemAddr = mem_addr_q;
    assign Output_IF_Instru         = instru_q;
    assign Output_IF_IRWrite        = irwrite_q;
    assign Output_IF_PC             = pc_q;
    assign Output_IF_Valid          = !fifo_empty_s;

`ifdef IFU_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Stall counter next-state: waiting fetch without delivery, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pending_q && !irwrite_q && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge CLK or negedge input_IF_Reset_n) begin
        if (!input_IF_Reset_n) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Output_IF_StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit: the bench plays instruction
// memory and control unit, with hand-computed expectations at each step.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        fetch;
    logic        redirect;
    logic [15:0] target;
    logic [15:0] instru;
    logic        irwrite;
    logic [15:0] pc;
    logic        valid;
`ifdef IFU_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    instruction_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

    instruction_fetch_unit dut (
        .CLK                (CLK),
        .input_IF_Reset_n   (rst_n),
        .mem_if             (mem_if),
        .input_IF_Fetch     (fetch),
        .input_IF_Redirect  (redirect),
        .input_IF_Target    (target),
        .Output_IF_Instru   (instru),
        .Output_IF_IRWrite  (irwrite),
        .Output_IF_PC       (pc),
        .Output_IF_Valid    (valid)
`ifdef IFU_PERF_EN
        ,
        .Output_IF_StallCnt (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_memreq"},  mem_if.Output_IF_MemReq,  32'h0);
        chk({tag, "_memaddr"}, mem_if.Output_IF_MemAddr, 32'h0000);
        chk({tag, "_instru"},  instru,  32'h0);
        chk({tag, "_irwrite"}, irwrite, 32'h0);
        chk({tag, "_pc"},      pc,      32'h0);
        chk({tag, "_valid"},   valid,   32'h0);
`ifdef IFU_PERF_EN
        chk({tag, "_stall"},   stall_cnt, 32'h0);
`endif
    endtask

    initial begin
        rst_n    = 1'b1;
        fetch    = 1'b0;
        redirect = 1'b0;
        target   = 16'h0000;
        mem_if.input_IF_MemAck  = 1'b0;
        mem_if.input_IF_MemData = 16'h0000;
        #1 rst_n = 1'b0;
        #1;
        chk_reset_values("rst0");
        step();
        step();
        rst_n = 1'b1;
        // First request one cycle after release.
        step();
        chk("t1_memreq",  mem_if.Output_IF_MemReq,  32'h1);
        chk("t1_memaddr", mem_if.Output_IF_MemAddr, 32'h0000);

        // Test 2: ack 0x1A2B, then fetch it.
        mem_if.input_IF_MemAck  = 1'b1;
        mem_if.input_IF_MemData = 16'h1A2B;
        step();
        chk("t2_valid",   valid, 32'h1);
        chk("t2_memaddr", mem_if.Output_IF_MemAddr, 32'h0002);
        chk("t2_irw0",    irwrite, 32'h0);
        mem_if.input_IF_MemAck = 1'b0;
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        chk("t2_irw1",    irwrite, 32'h1);
        chk("t2_instru",  instru,  32'h1A2B);
        chk("t2_pc",      pc,      32'h0000);
        chk("t2_valid0",  valid,   32'h0);
        step();
        chk("t2_irw_one", irwrite, 32'h0);

        // Test 3: fill FIFO (acks at 0x0002, 0x0004), request drops.
        mem_if.input_IF_MemAck  = 1'b1;
        mem_if.input_IF_MemData = 16'h1111;
        step();
        chk("t3_addr1", mem_if.Output_IF_MemAddr, 32'h0004);
        chk("t3_req1",  mem_if.Output_IF_MemReq,  32'h1);
        mem_if.input_IF_MemData = 16'h2222;
        step();
        mem_if.input_IF_MemAck = 1'b0;
        chk("t3_req_full",  mem_if.Output_IF_MemReq,  32'h0);
        chk("t3_valid",     valid, 32'h1);
        chk("t3_addr_full", mem_if.Output_IF_MemAddr, 32'h0006);
        step();
        chk("t3_req_idle",  mem_if.Output_IF_MemReq,  32'h0);
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        chk("t3_irw",    irwrite, 32'h1);
        chk("t3_instru", instru,  32'h1111);
        chk("t3_pc",     pc,      32'h0002);
        chk("t3_req",    mem_if.Output_IF_MemReq,  32'h1);
        chk("t3_addr",   mem_if.Output_IF_MemAddr, 32'h0006);
        chk("t3_valid1", valid, 32'h1);

        // Test 4: redirect to 0x0100 while 0x0006 is open.
        redirect = 1'b1;
        target   = 16'h0100;
        step();
        redirect = 1'b0;
        chk("t4_addr_held", mem_if.Output_IF_MemAddr, 32'h0006);
        chk("t4_req",       mem_if.Output_IF_MemReq,  32'h1);
        chk("t4_valid",     valid,   32'h0);
        chk("t4_irw",       irwrite, 32'h0);
        mem_if.input_IF_MemAck  = 1'b1;
        mem_if.input_IF_MemData = 16'hDEAD;
        step();
        mem_if.input_IF_MemAck = 1'b0;
        chk("t4_drop_irw",   irwrite, 32'h0);
        chk("t4_drop_valid", valid,   32'h0);
        chk("t4_new_addr",   mem_if.Output_IF_MemAddr, 32'h0100);
        chk("t4_new_req",    mem_if.Output_IF_MemReq,  32'h1);

        // Test 5: fetch on empty FIFO, served by bypass after a wait.
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        chk("t5_wait_irw", irwrite, 32'h0);
        step();
        step();
        step();
        chk("t5_wait_irw3", irwrite, 32'h0);
        mem_if.input_IF_MemAck  = 1'b1;
        mem_if.input_IF_MemData = 16'h4321;
        step();
        mem_if.input_IF_MemAck = 1'b0;
        chk("t5_irw",    irwrite, 32'h1);
        chk("t5_instru", instru,  32'h4321);
        chk("t5_pc",     pc,      32'h0100);
        chk("t5_valid",  valid,   32'h0);
        chk("t5_addr",   mem_if.Output_IF_MemAddr, 32'h0102);
`ifdef IFU_PERF_EN
        chk("t5_stall",  stall_cnt, 32'h4);
`endif
        step();
        chk("t5_irw_one", irwrite, 32'h0);

        // Test 6: redirect (with stale ack) to 0xFFFE, addresses wrap.
        redirect = 1'b1;
        target   = 16'hFFFE;
        mem_if.input_IF_MemAck  = 1'b1;
        mem_if.input_IF_MemData = 16'hBAD0;
        step();
        redirect = 1'b0;
        chk("t6_addr0",  mem_if.Output_IF_MemAddr, 32'hFFFE);
        chk("t6_valid0", valid,   32'h0);
        chk("t6_irw0",   irwrite, 32'h0);
        mem_if.input_IF_MemData = 16'h5555;
        step();
        chk("t6_addr1",  mem_if.Output_IF_MemAddr, 32'h0000);
        chk("t6_valid1", valid, 32'h1);
        mem_if.input_IF_MemData = 16'h6666;
        step();
        mem_if.input_IF_MemAck = 1'b0;
        chk("t6_req_full", mem_if.Output_IF_MemReq,  32'h0);
        chk("t6_addr2",    mem_if.Output_IF_MemAddr, 32'h0002);
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        chk("t6_irw_a",    irwrite, 32'h1);
        chk("t6_instru_a", instru,  32'h5555);
        chk("t6_pc_a",     pc,      32'hFFFE);
        step();
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        chk("t6_irw_b",    irwrite, 32'h1);
        chk("t6_instru_b", instru,  32'h6666);
        chk("t6_pc_b",     pc,      32'h0000);
        chk("t6_valid_b",  valid,   32'h0);

        // Reset asserted mid-request with non-zero state everywhere.
        mem_if.input_IF_MemAck  = 1'b1;
        mem_if.input_IF_MemData = 16'h7777;
        step();
        mem_if.input_IF_MemAck = 1'b0;
        chk("rst1_pre_valid", valid, 32'h1);
        chk("rst1_pre_addr",  mem_if.Output_IF_MemAddr, 32'h0004);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_values("rst1");
        #2 rst_n = 1'b1;
        step();
        chk("rst1_rel_req",  mem_if.Output_IF_MemReq,  32'h1);
        chk("rst1_rel_addr", mem_if.Output_IF_MemAddr, 32'h0000);
        chk("rst1_rel_valid", valid, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
